// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared access-size encodings, reset-content modes and the
//                reset-content helper for the data memory bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size encoding carried on the size port
  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  // Reset-content modes
  localparam int INIT_ZERO = 0;
  localparam int INIT_SEQ  = 1;

  // Byte value held at a byte address right after reset
  function automatic logic [7:0] init_byte(input int mode, input logic [31:0] byte_addr);
    init_byte = (mode == INIT_SEQ) ? (byte_addr[7:0] + 8'd1) : 8'h00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_align
//  Description : Combinational load aligner: selects the addressed lanes of a
//                raw little-endian word, right-justifies them and sign- or
//                zero-extends to 32 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        signed_load,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lanes and extend them according to size and signedness
  always_comb begin
    w_byte    = 8'(raw_word >> {lane, 3'b000});
    // Half accesses are 2-byte aligned, so only the upper lane bit selects
    w_half    = 16'(raw_word >> {lane[1], 4'b0000});
    load_data = raw_word;
    case (size)
      SZ_BYTE: load_data = {{24{signed_load & w_byte[7]}}, w_byte};
      SZ_HALF: load_data = {{16{signed_load & w_half[15]}}, w_half};
      default: load_data = raw_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_bank.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_bank
//  Description : Byte-addressable MEM-stage data memory. Byte/half/word
//                loads and stores, registered one-cycle load response,
//                rejection of misaligned, out-of-range and conflicting
//                requests without touching storage.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_bank
  import mem_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 32,
  parameter int INIT_MODE = INIT_SEQ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic [ADDR_W-1:0] aluOut,
  input  logic [31:0]       dataIn,
  input  logic [1:0]        size,
  input  logic              signedLoad,
  output logic [31:0]       dataMemOut,
  output logic              memValid,
  output logic              memErr,
  output logic              errSticky
);

  localparam int c_IDX_W = $clog2(DEPTH);

  logic [7:0]         r_mem [DEPTH][4];
  logic               r_armed;
  logic [31:0]        r_data;
  logic               r_valid;
  logic               r_err;
  logic               r_sticky;

  logic [c_IDX_W-1:0] w_idx;
  logic [1:0]         w_lane;
  logic               w_oor;
  logic               w_req;
  logic               w_bad;
  logic               w_ok;
  logic               w_do_write;
  logic [3:0]         w_lane_we;
  logic [31:0]        w_wdata;
  logic [31:0]        w_raw;
  logic [31:0]        w_load;

  assign w_idx  = aluOut[c_IDX_W+1:2];
  assign w_lane = aluOut[1:0];

  // Any address bit above the storage range makes the access illegal
  generate
    if (ADDR_W > c_IDX_W + 2) begin : g_range_chk
      assign w_oor = |aluOut[ADDR_W-1:c_IDX_W+2];
    end else begin : g_no_range_chk
      assign w_oor = 1'b0;
    end
  endgenerate

  // Classify the current request as accepted or rejected
  always_comb begin
    w_req = memRead | memWrite;
    w_bad = (memRead & memWrite)
          | (size == SZ_ILLEGAL)
          | ((size == SZ_HALF) & w_lane[0])
          | ((size == SZ_WORD) & (w_lane != 2'b00))
          | w_oor;
    w_ok       = w_req & ~w_bad;
    w_do_write = r_armed & w_ok & memWrite;
  end

  // Store lane enables and data replicated onto every lane position
  always_comb begin
    w_lane_we = 4'b0000;
    w_wdata   = dataIn;
    case (size)
      SZ_BYTE: begin
        w_lane_we = 4'b0001 << w_lane;
        w_wdata   = {4{dataIn[7:0]}};
      end
      SZ_HALF: begin
        w_lane_we = 4'b0011 << w_lane;
        w_wdata   = {2{dataIn[15:0]}};
      end
      SZ_WORD: begin
        w_lane_we = 4'b1111;
        w_wdata   = dataIn;
      end
      default: begin
        w_lane_we = 4'b0000;
        w_wdata   = dataIn;
      end
    endcase
  end

  assign w_raw = {r_mem[w_idx][3], r_mem[w_idx][2], r_mem[w_idx][1], r_mem[w_idx][0]};

  mem_load_align u_load_align (
    .raw_word    (w_raw),
    .lane        (w_lane),
    .size        (size),
    .signed_load (signedLoad),
    .load_data   (w_load)
  );

  // Storage: reloaded with the reset pattern, written lane-wise on accepted stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        for (int l = 0; l < 4; l++) begin
          r_mem[w][l] <= init_byte(INIT_MODE, 32'(w * 4 + l));
        end
      end
    end else if (w_do_write) begin
      for (int l = 0; l < 4; l++) begin
        if (w_lane_we[l]) begin
          r_mem[w_idx][l] <= w_wdata[8*l +: 8];
        end
      end
    end
  end

  // Masks the edge on which reset is released so no request is serviced there
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_armed <= 1'b0;
    else       r_armed <= 1'b1;
  end

  // Registered response: load data, completion and rejection pulses, sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= 32'h0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else if (r_armed) begin
      r_valid <= w_ok;
      r_err   <= w_req & w_bad;
      if (w_req & w_bad) r_sticky <= 1'b1;
      if (w_ok & memRead) r_data <= w_load;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  assign dataMemOut = r_data;
  assign memValid   = r_valid;
  assign memErr     = r_err;
  assign errSticky  = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_bank
//  Description : Self-checking bench for data_mem_bank: directed vector table,
//                asynchronous reset sequence and randomized traffic checked
//                against a byte-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_bank;

  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 32;
  localparam int INIT_MODE = 1;
  localparam int NBYTES    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memWrite;
  logic        memRead;
  logic [31:0] aluOut;
  logic [31:0] dataIn;
  logic [1:0]  size;
  logic        signedLoad;
  logic [31:0] dataMemOut;
  logic        memValid;
  logic        memErr;
  logic        errSticky;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  m_mem [NBYTES];
  logic [31:0] m_data;
  logic        m_v;
  logic        m_e;
  logic        m_s;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] exp_data;
    logic        exp_v;
    logic        exp_e;
    logic        exp_s;
  } vec_t;

  vec_t tbl[$];

  data_mem_bank #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_MODE (INIT_MODE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memWrite   (memWrite),
    .memRead    (memRead),
    .aluOut     (aluOut),
    .dataIn     (dataIn),
    .size       (size),
    .signedLoad (signedLoad),
    .dataMemOut (dataMemOut),
    .memValid   (memValid),
    .memErr     (memErr),
    .errSticky  (errSticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] d, input logic v,
                         input logic e, input logic s);
    chk({tag, " data"},   dataMemOut,       d);
    chk({tag, " valid"},  {31'b0, memValid},  {31'b0, v});
    chk({tag, " err"},    {31'b0, memErr},    {31'b0, e});
    chk({tag, " sticky"}, {31'b0, errSticky}, {31'b0, s});
  endtask

  task automatic model_reset();
    for (int b = 0; b < NBYTES; b++) m_mem[b] = 8'(b + 1);
    m_data = 32'h0;
    m_v    = 1'b0;
    m_e    = 1'b0;
    m_s    = 1'b0;
  endtask

  // Expected result of one request, from the access rules on a flat byte array
  task automatic model_step(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] din, input logic [1:0] sz, input logic sgn);
    bit          bad;
    int          nb;
    logic [31:0] v;
    if (!wr && !rd) begin
      m_v = 1'b0;
      m_e = 1'b0;
    end else begin
      bad = (wr && rd) || (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
            (sz == 2'd2 && addr % 4 != 0) || (addr >= 32'(NBYTES));
      m_v = !bad;
      m_e = bad;
      if (bad) begin
        m_s = 1'b1;
      end else begin
        nb = 1 << sz;
        if (wr) begin
          for (int k = 0; k < nb; k++) m_mem[int'(addr) + k] = 8'(din >> (8 * k));
        end else begin
          v = 32'h0;
          for (int k = 0; k < nb; k++) v = v | (32'(m_mem[int'(addr) + k]) << (8 * k));
          if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
          m_data = v;
        end
      end
    end
  endtask

  // Drive one request at the falling edge, then sample just after the rising edge
  task automatic apply(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] din, input logic [1:0] sz, input logic sgn);
    @(negedge clk);
    memWrite   = wr;
    memRead    = rd;
    aluOut     = addr;
    dataIn     = din;
    size       = sz;
    signedLoad = sgn;
    model_step(wr, rd, addr, din, sz, sgn);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    memWrite   = 1'b0;
    memRead    = 1'b0;
    aluOut     = 32'h0;
    dataIn     = 32'h0;
    size       = 2'b00;
    signedLoad = 1'b0;
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] din, input logic [1:0] sz, input logic sgn,
                              input logic [31:0] d, input logic v, input logic e, input logic s);
    vec_t t;
    t.wr = wr; t.rd = rd; t.addr = addr; t.din = din; t.sz = sz; t.sgn = sgn;
    t.exp_data = d; t.exp_v = v; t.exp_e = e; t.exp_s = s;
    return t;
  endfunction

  initial begin
    logic        r_wr;
    logic        r_rd;
    logic [31:0] r_addr;
    int          sel;

    //         wr rd addr          din           sz sgn  exp_data      v  e  s
    tbl.push_back(mk(0, 1, 32'h00,       32'h0,        2, 0, 32'h04030201, 1, 0, 0));
    tbl.push_back(mk(1, 0, 32'h02,       32'h0000BEEF, 1, 0, 32'h04030201, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h00,       32'h0,        2, 0, 32'hBEEF0201, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h03,       32'h0,        0, 1, 32'hFFFFFFBE, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h03,       32'h0,        0, 0, 32'h000000BE, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h02,       32'h0,        1, 1, 32'hFFFFBEEF, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h02,       32'h0,        1, 0, 32'h0000BEEF, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h02,       32'h0,        2, 0, 32'h0000BEEF, 0, 1, 1));
    tbl.push_back(mk(1, 0, 32'h01,       32'h00001234, 1, 0, 32'h0000BEEF, 0, 1, 1));
    tbl.push_back(mk(0, 1, 32'h00,       32'h0,        3, 0, 32'h0000BEEF, 0, 1, 1));
    tbl.push_back(mk(0, 1, 32'h00,       32'h0,        2, 0, 32'hBEEF0201, 1, 0, 1));
    tbl.push_back(mk(0, 1, 32'h40,       32'h0,        2, 0, 32'hBEEF0201, 0, 1, 1));
    tbl.push_back(mk(1, 1, 32'h04,       32'hDEADBEEF, 2, 0, 32'hBEEF0201, 0, 1, 1));
    tbl.push_back(mk(0, 1, 32'h04,       32'h0,        2, 0, 32'h08070605, 1, 0, 1));
    tbl.push_back(mk(1, 0, 32'h08,       32'h11223344, 2, 0, 32'h08070605, 1, 0, 1));
    tbl.push_back(mk(0, 1, 32'h08,       32'h0,        2, 0, 32'h11223344, 1, 0, 1));
    tbl.push_back(mk(0, 0, 32'h08,       32'h0,        2, 0, 32'h11223344, 0, 0, 1));
    tbl.push_back(mk(0, 1, 32'h3C,       32'h0,        2, 0, 32'h403F3E3D, 1, 0, 1));
    tbl.push_back(mk(0, 1, 32'h3F,       32'h0,        0, 1, 32'h00000040, 1, 0, 1));
    tbl.push_back(mk(1, 0, 32'h3F,       32'hFFFFFF80, 0, 0, 32'h00000040, 1, 0, 1));
    tbl.push_back(mk(0, 1, 32'h3F,       32'h0,        0, 1, 32'hFFFFFF80, 1, 0, 1));
    tbl.push_back(mk(0, 1, 32'h3C,       32'h0,        2, 0, 32'h803F3E3D, 1, 0, 1));
    tbl.push_back(mk(0, 1, 32'h80000000, 32'h0,        2, 0, 32'h803F3E3D, 0, 1, 1));

    // Power-on reset
    drive_idle();
    reset = 1'b1;
    model_reset();
    #1;
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;   // the next rising edge carries no request

    // Directed vector table
    foreach (tbl[i]) begin
      apply(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].din, tbl[i].sz, tbl[i].sgn);
      chk_all($sformatf("row%0d", i), tbl[i].exp_data, tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_s);
    end

    // Reset asserted the cycle after a load, between clock edges
    apply(1'b0, 1'b1, 32'h00, 32'h0, 2'd2, 1'b0);
    chk_all("preload", 32'hBEEF0201, 1'b1, 1'b0, 1'b1);
    drive_idle();
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 1'b1, 32'h08, 32'h0, 2'd2, 1'b0);
    chk_all("post_rst w8", 32'h0C0B0A09, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 32'h00, 32'h0, 2'd2, 1'b0);
    chk_all("post_rst w0", 32'h04030201, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      sel  = int'($urandom_range(0, 9));
      r_rd = (sel <= 3) || (sel == 8);
      r_wr = (sel >= 4 && sel <= 8);
      if ($urandom_range(0, 9) == 0) r_addr = $urandom;
      else                           r_addr = 32'($urandom_range(0, NBYTES + 3));
      apply(r_wr, r_rd, r_addr, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      chk_all($sformatf("rand%0d", n), m_data, m_v, m_e, m_s);
    end

    drive_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
